// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU: address/instruction widths, the
// opcode set, instruction field positions and small helpers for building
// and taking apart instruction words. Used by the program ROM, the decoder
// and the CPU core so that all of them agree on one encoding.
//
// Instruction word layout (INSTR_W = 16):
//   [15:12] opcode
//   [11:8]  destination register
//   [7:0]   immediate or source field
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 8;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [OPC_W-1:0]   opc_t;
    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [IMM_W-1:0]   imm_t;

    // Opcode constants. Every other opcode value is reserved.
    localparam opc_t OPC_NOP = 4'h0;
    localparam opc_t OPC_LDI = 4'h1;
    localparam opc_t OPC_ADD = 4'h2;
    localparam opc_t OPC_HLT = 4'hF;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = OPC_NOP,
        OP_LDI = OPC_LDI,
        OP_ADD = OPC_ADD,
        OP_HLT = OPC_HLT
    } opcode_e;

    // Word returned for every unprogrammed address; decodes as NOP.
    localparam instr_t DEFAULT_INSTR = 16'h0000;

    // Assemble an instruction word from its three fields.
    function automatic instr_t make_instr(input opc_t opc, input reg_t rd, input imm_t imm);
        instr_t w;
        w                  = DEFAULT_INSTR;
        w[OPC_MSB:OPC_LSB] = opc;
        w[RD_MSB:RD_LSB]   = rd;
        w[IMM_MSB:IMM_LSB] = imm;
        return w;
    endfunction

    function automatic opc_t instr_opc(input instr_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic reg_t instr_rd(input instr_t w);
        return w[RD_MSB:RD_LSB];
    endfunction

    function automatic imm_t instr_imm(input instr_t w);
        return w[IMM_MSB:IMM_LSB];
    endfunction

    // True for opcodes outside the defined set.
    function automatic logic opc_reserved(input opc_t opc);
        return !(opc == OPC_NOP || opc == OPC_LDI || opc == OPC_ADD || opc == OPC_HLT);
    endfunction

endpackage

// File: rtl/program_rom_table.sv
// ---------------------------------------------------------------------------
// rom_table
// Purely combinational program image: full 8-bit address decode into a
// 16-bit instruction word. Only 0x00-0x03 hold code; every other address,
// including 0xFF, returns DEFAULT_INSTR (NOP).
//
// Ports:
//   addr_i  in   ADDR_W   instruction address
//   word_o  out  INSTR_W  instruction word at addr_i
// ---------------------------------------------------------------------------
module rom_table
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [INSTR_W-1:0] word_o
);

    always_comb begin
        word_o = DEFAULT_INSTR;
        case (addr_i)
            8'h00:   word_o = make_instr(OPC_LDI, 4'd0, 8'h05);  // LDI r0, 0x05
            8'h01:   word_o = make_instr(OPC_LDI, 4'd1, 8'h03);  // LDI r1, 0x03
            8'h02:   word_o = make_instr(OPC_ADD, 4'd0, 8'h01);  // ADD r0, r1
            8'h03:   word_o = make_instr(OPC_HLT, 4'd0, 8'h00);  // HLT
            default: word_o = DEFAULT_INSTR;
        endcase
    end

endmodule

// File: rtl/program_rom.sv
// ---------------------------------------------------------------------------
// program_rom
// Read-only program store between the program counter and the instruction
// decoder. Provides the fetched word combinationally and a one-cycle
// registered copy for pipelined consumers. No write port.
//
// Ports:
//   clk     in   1        system clock, rising edge
//   rst_n   in   1        asynchronous active-low reset (clears data_q only)
//   addr    in   ADDR_W   instruction address
//   data    out  INSTR_W  combinational instruction word at addr
//   data_q  out  INSTR_W  data registered on the rising edge of clk
// ---------------------------------------------------------------------------
module program_rom
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] data,
    output logic [INSTR_W-1:0] data_q
);

    logic [INSTR_W-1:0] data_d;

    rom_table u_rom_table (
        .addr_i (addr),
        .word_o (data_d)
    );

    // The combinational path is independent of clk and rst_n.
    assign data = data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_program_rom.sv
module tb_program_rom;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr  = 8'h00;
    logic [15:0] data;
    logic [15:0] data_q;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: the program image as a 256-entry table.
    logic [15:0] img [256];
    logic [15:0] exp_q  = 16'h0000;
    bit          cmp_en = 1'b0;

    // Hand-written program words, used to pin both DUT and model.
    logic [15:0] prog_lit [4];
    logic [7:0]  dflt_addr [3];

    program_rom dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .data   (data),
        .data_q (data_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t addr=%h)", name, act, exp, $time, addr);
        end
    endtask

    // Expected registered output: whatever the table said at the last
    // rising edge while out of reset, cleared at once when reset falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 16'h0000;
        else        exp_q <= img[addr];
    end

    // Continuous comparison on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("data_vs_model", data, img[addr]);
            check("data_q_vs_model", data_q, exp_q);
        end
    end

    task automatic step(input logic [7:0] a);
        @(posedge clk);
        #2 addr = a;
    endtask

    initial begin
        int nz;
        for (int i = 0; i < 256; i++) img[i] = 16'h0000;
        img[0] = 16'h1005;
        img[1] = 16'h1103;
        img[2] = 16'h2001;
        img[3] = 16'hF000;
        prog_lit[0] = 16'h1005;
        prog_lit[1] = 16'h1103;
        prog_lit[2] = 16'h2001;
        prog_lit[3] = 16'hF000;
        dflt_addr[0] = 8'h04;
        dflt_addr[1] = 8'h80;
        dflt_addr[2] = 8'hFF;

        // Reset held with addr = 0.
        rst_n = 1'b0;
        addr  = 8'h00;
        repeat (3) @(posedge clk);
        #2 cmp_en = 1'b1;
        #1;
        check("reset_data", data, 16'h1005);
        check("reset_data_q", data_q, 16'h0000);

        // Release, first edge loads the current word.
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_load_data_q", data_q, 16'h1005);

        // Combinational sweep of the programmed words.
        for (int i = 0; i < 4; i++) begin
            step(8'(i));
            #1 check("sweep_data", data, prog_lit[i]);
        end

        // data_q lags data by one cycle while stepping 0..3.
        step(8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("lag_data_q", data_q, prog_lit[i]);
            if (i < 3) #1 addr = 8'(i + 1);
        end

        // Unprogrammed addresses read as NOP.
        for (int i = 0; i < 3; i++) begin
            step(dflt_addr[i]);
            #1 check("default_data", data, 16'h0000);
        end

        // Reset asserted between edges clears data_q immediately.
        step(8'h02);
        @(posedge clk);
        #1 check("pre_reset_data_q", data_q, 16'h2001);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear_data_q", data_q, 16'h0000);
        check("data_during_reset", data, 16'h2001);
        repeat (2) @(posedge clk);
        #1 check("hold_reset_data_q", data_q, 16'h0000);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_release_data_q", data_q, 16'h2001);

        // Exhaustive sweep: no X, only 0x00-0x03 nonzero.
        nz = 0;
        for (int a = 0; a < 256; a++) begin
            step(8'(a));
            #1;
            n_cmp++;
            if ($isunknown(data)) begin
                n_fail++;
                $display("FAIL x_on_data: got %h, expected defined value at addr %h", data, addr);
            end
            if (data !== 16'h0000) nz++;
            check("exhaustive_data", data, (a < 4) ? prog_lit[a] : 16'h0000);
        end
        n_cmp++;
        if (nz != 4) begin
            n_fail++;
            $display("FAIL nonzero_count: got %0d, expected 4", nz);
        end

        // Random addresses with occasional asynchronous reset pulses.
        for (int k = 0; k < 400; k++) begin
            step(8'($urandom_range(0, 255)));
            if (rst_n && $urandom_range(0, 19) == 0) begin
                #1 rst_n = 1'b0;
            end else if (!rst_n && $urandom_range(0, 2) == 0) begin
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_rom.md
# program_rom

Read-only program store for the 8-bit CPU: maps an 8-bit instruction address to a 16-bit instruction word. Sits between the program counter and the instruction decoder. It provides a zero-latency combinational fetch path and a registered copy of the fetched word for pipelined consumers. Contents are fixed at synthesis; there is no write port.

## Interface
- No parameters; widths and contents are fixed constants from the shared package.
- `clk`  input  1  system clock; rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `addr`  input  8  instruction address, 0x00–0xFF.
- `data`  output  16  combinational instruction word at `addr`.
- `data_q`  output  16  `data` registered on the rising edge of `clk`.

## Operation
- Instruction format: [15:12] opcode, [11:8] destination register field, [7:0] immediate or source field.
- Opcodes (package constants): NOP=4'h0, LDI=4'h1, ADD=4'h2, HLT=4'hF. All other opcodes are reserved.
- Required image:
  - 0x00 = 16'h1005 (LDI r0, 0x05)
  - 0x01 = 16'h1103 (LDI r1, 0x03)
  - 0x02 = 16'h2001 (ADD r0, r1)
  - 0x03 = 16'hF000 (HLT)
- Every other address (0x04–0xFF) returns the default word 16'h0000 (NOP).
- Full 8-bit decode. No aliasing, no wrap-around logic: address 0xFF is an ordinary default entry.
- `data` is a pure function of `addr`:
  - unaffected by `clk` and `rst_n`;
  - never X for any fully defined `addr`.
- X/Z on `addr` does not need a defined `data` value.

## Timing
- `data`: combinational. It must be valid within the same delta/time step after `addr` changes. Benches sample 1 time unit after the change.
- `data_q`:
  - loads `data` on each rising `clk` edge while `rst_n`=1, giving a 1-cycle latency;
  - when `rst_n` falls, it clears to 16'h0000 immediately, without waiting for a clock edge;
  - holds 16'h0000 while `rst_n`=0;
  - after `rst_n` rises, the first rising edge loads the word for the current `addr`.
- Reset mid-operation: `data_q` goes to 0 immediately and `data` keeps tracking `addr`.
- There is no enable. `data_q` updates every cycle.

## Structure
- Shared package `cpu_pkg`, holding:
  - ADDR_W=8, INSTR_W=16;
  - opcode constants;
  - field position constants;
  - DEFAULT_INSTR=16'h0000.
- The decoder and CPU reuse the same opcode constants.
- One sub-module, `rom_table`: a purely combinational `addr`→word case table with a default branch.
- The top level adds only the `data_q` register, with asynchronous reset.

## Test plan
- Sweep `addr` 0x00, 0x01, 0x02, 0x03, checking `data` 1 time unit after each change -> 0x1005, 0x1103, 0x2001, 0xF000.
- `addr`=0x04, 0x80, 0xFF -> `data`=0x0000 (default NOP).
- Hold `rst_n`=0 with `addr`=0x00 -> `data`=0x1005 and `data_q`=0x0000. Release, then one rising edge -> `data_q`=0x1005.
- Step `addr` 0x00→0x03 on successive clocks -> `data_q` lags `data` by exactly one cycle: 0x1005, 0x1103, 0x2001, 0xF000.
- With `addr`=0x02 and `data_q`=0x2001, assert `rst_n`=0 between clock edges -> `data_q`=0x0000 immediately, with no clock edge.
- Exhaustive sweep of 0x00–0xFF -> only 0x00–0x03 are nonzero, and no X appears on `data`.
